// File: rtl/enc8to3_arb.sv
// enc8to3_arb: sequential 8-to-3 encoder with sticky request capture,
// fixed-priority or round-robin arbitration, and a Valid/Ack handshake.
// The encoding counterpart of the 3-to-8 decoder: the granted source's
// index is presented on y and held until the consumer acknowledges it.
module enc8to3_arb #(
    parameter int RR_EN = 1              // 1 = round-robin, 0 = fixed priority (bit 0 highest)
) (
    input  logic       clock,
    input  logic       reset,            // synchronous, active-high
    input  logic [7:0] req,
    input  logic       en,
    input  logic       ack,
    output logic [2:0] y,
    output logic       valid,
    output logic [7:0] pend
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Lowest set bit of c; 0 when c is empty (callers gate on c != 0).
    function automatic logic [2:0] pick_lowest(input logic [7:0] c);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = c[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    // First set bit of c searching ptr, ptr+1, ..., wrapping modulo 8.
    // Rotating c right by ptr puts c[ptr] at bit 0, so the lowest set bit
    // of the rotated vector plus ptr (3-bit wrap) is the answer.
    function automatic logic [2:0] pick_from(input logic [7:0] c, input logic [2:0] ptr);
        logic [15:0] dbl;
        logic [7:0]  rot;
        dbl = {c, c} >> ptr;
        rot = dbl[7:0];
        return ptr + pick_lowest(rot);
    endfunction

    // One-hot decode of a source index, used to clear the granted pend bit.
    function automatic logic [7:0] dec3to8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [2:0] y_r;
    logic [2:0] y_s;
    logic       valid_r;
    logic       valid_s;
    logic [7:0] pend_r;
    logic [7:0] pend_s;
    logic [2:0] ptr_r;
    logic [2:0] ptr_s;
    logic [7:0] cand_s;
    logic [2:0] sel_s;

    // Candidate set and the arbitration winner for this cycle.
    always_comb begin
        cand_s = pend_r | req;
        if (RR_EN != 0) begin
            sel_s = pick_from(cand_s, ptr_r);
        end else begin
            sel_s = pick_lowest(cand_s);
        end
    end

    // Next-state, next-grant and pend/ptr update logic.
    always_comb begin
        state_s = state_r;
        y_s     = y_r;
        valid_s = valid_r;
        ptr_s   = ptr_r;
        pend_s  = pend_r | req;          // capture runs every cycle
        case (state_r)
            IDLE: begin
                // ack is ignored here: nothing is granted yet
                if (en && (cand_s != 8'd0)) begin
                    state_s = GRANT;
                    y_s     = sel_s;
                    valid_s = 1'b1;
                end else begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                end
            end
            GRANT: begin
                // y/valid hold regardless of en or new requests until ack
                if (ack) begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    ptr_s   = y_r + 3'd1;
                    // a fresh request on the granted line re-sets its bit
                    pend_s  = (pend_r & ~dec3to8(y_r)) | req;
                end else begin
                    state_s = GRANT;
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            y_r     <= 3'd0;
            valid_r <= 1'b0;
            pend_r  <= 8'd0;
            ptr_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            y_r     <= y_s;
            valid_r <= valid_s;
            pend_r  <= pend_s;
            ptr_r   <= ptr_s;
        end
    end

    assign y     = y_r;
    assign valid = valid_r;
    assign pend  = pend_r;

endmodule

// File: tb/tb_enc8to3_arb.sv
// Self-checking bench for enc8to3_arb: a round-robin and a fixed-priority
// instance share the same stimulus and are each compared every cycle
// against a behavioural model; literal checks pin the model on key cases.
module tb_enc8to3_arb;

    logic       clock;
    logic       reset;
    logic [7:0] req;
    logic       en;
    logic       ack;
    logic [2:0] y_rr, y_fp;
    logic       valid_rr, valid_fp;
    logic [7:0] pend_rr, pend_fp;

    int checks   = 0;
    int failures = 0;

    // model state, index 1 = round-robin, index 0 = fixed priority
    logic [7:0] m_pend  [2];
    int         m_y     [2];
    logic       m_valid [2];
    int         m_ptr   [2];

    enc8to3_arb #(.RR_EN(1)) dut_rr (
        .clock(clock), .reset(reset), .req(req), .en(en), .ack(ack),
        .y(y_rr), .valid(valid_rr), .pend(pend_rr)
    );

    enc8to3_arb #(.RR_EN(0)) dut_fp (
        .clock(clock), .reset(reset), .req(req), .en(en), .ack(ack),
        .y(y_fp), .valid(valid_fp), .pend(pend_fp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic [7:0] c;
            logic [7:0] np;
            if (reset) begin
                m_pend[m]  = 8'd0;
                m_y[m]     = 0;
                m_valid[m] = 1'b0;
                m_ptr[m]   = 0;
            end else begin
                c  = m_pend[m] | req;
                np = m_pend[m] | req;
                if (m_valid[m]) begin
                    if (ack) begin
                        if (!req[m_y[m]]) np[m_y[m]] = 1'b0;
                        m_ptr[m]   = (m_y[m] + 1) % 8;
                        m_valid[m] = 1'b0;
                    end
                end else if (en && c != 8'd0) begin
                    int start;
                    int found;
                    start = (m == 1) ? m_ptr[m] : 0;
                    found = -1;
                    for (int k = 0; k < 8; k++) begin
                        if (found < 0 && c[(start + k) % 8]) found = (start + k) % 8;
                    end
                    m_y[m]     = found;
                    m_valid[m] = 1'b1;
                end
                m_pend[m] = np;
            end
        end
    endtask

    // One clock: apply inputs, step model at the edge, compare 1 time unit later.
    task automatic tick(input logic r, input logic [7:0] rq, input logic e, input logic a);
        reset = r; req = rq; en = e; ack = a;
        @(posedge clock);
        model_step();
        #1;
        chk("rr_valid", 32'(valid_rr), 32'(m_valid[1]));
        chk("rr_y",     32'(y_rr),     m_y[1]);
        chk("rr_pend",  32'(pend_rr),  32'(m_pend[1]));
        chk("fp_valid", 32'(valid_fp), 32'(m_valid[0]));
        chk("fp_y",     32'(y_fp),     m_y[0]);
        chk("fp_pend",  32'(pend_fp),  32'(m_pend[0]));
    endtask

    initial begin
        int exp_y [8];
        int exp_v [8];
        reset = 1'b1; req = 8'd0; en = 1'b0; ack = 1'b0;
        #2;

        // reset state
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'hFF, 1'b1, 1'b1);       // reset dominates req/ack
        chk("lit_reset_valid", 32'(valid_rr), 0);
        chk("lit_reset_y",     32'(y_rr),     0);
        chk("lit_reset_pend",  32'(pend_rr),  0);

        // single request, 1-cycle latency after reset release
        tick(1'b0, 8'h20, 1'b1, 1'b0);
        chk("lit_single_valid", 32'(valid_rr), 1);
        chk("lit_single_y",     32'(y_rr),     5);
        chk("lit_single_pend",  32'(pend_rr),  32'h20);
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        chk("lit_single_ack_valid", 32'(valid_rr), 0);
        chk("lit_single_ack_pend",  32'(pend_rr),  0);

        // round-robin fairness, ack held high (ignored while idle)
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        exp_y = '{0, 0, 7, 7, 0, 0, 7, 7};
        exp_v = '{1, 0, 1, 0, 1, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h81, 1'b1, 1'b1);
            chk("lit_rr_valid", 32'(valid_rr), exp_v[i]);
            if (exp_v[i] == 1) chk("lit_rr_y", 32'(y_rr), exp_y[i]);
            if (exp_v[i] == 1) chk("lit_fp81_y", 32'(y_fp), 0);
        end

        // fixed priority: bit 2 always beats bit 3
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'h0C, 1'b1, 1'b1);
            chk("lit_fp_valid", 32'(valid_fp), (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) chk("lit_fp_y", 32'(y_fp), 2);
        end

        // stickiness and hold during a waiting grant
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h02, 1'b1, 1'b0);
        tick(1'b0, 8'h10, 1'b1, 1'b0);
        chk("lit_hold_y", 32'(y_rr), 1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);       // en drop does not cancel
        chk("lit_hold_en_valid", 32'(valid_rr), 1);
        chk("lit_hold_pend", 32'(pend_rr), 32'h12);
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        chk("lit_hold_ack_pend", 32'(pend_rr), 32'h10);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_sticky_y", 32'(y_rr), 4);
        chk("lit_sticky_valid", 32'(valid_rr), 1);

        // enable gating and ack/request collision
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'hFF, 1'b0, 1'b0);
        tick(1'b0, 8'hFF, 1'b0, 1'b1);
        chk("lit_en0_valid", 32'(valid_rr), 0);
        chk("lit_en0_pend", 32'(pend_rr), 32'hFF);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_en1_y", 32'(y_rr), 0);
        tick(1'b0, 8'h01, 1'b1, 1'b1);
        chk("lit_collide_pend", 32'(pend_rr), 32'hFF);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_regrant_y", 32'(y_rr), 1);  // ptr advanced to 1

        // reset in the middle of a grant
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h20, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b1);       // ptr -> 6
        tick(1'b0, 8'h41, 1'b1, 1'b0);
        chk("lit_mid_y", 32'(y_rr), 6);
        chk("lit_mid_pend", 32'(pend_rr), 32'h41);
        tick(1'b1, 8'h41, 1'b1, 1'b1);
        chk("lit_mid_rst_valid", 32'(valid_rr), 0);
        chk("lit_mid_rst_y", 32'(y_rr), 0);
        chk("lit_mid_rst_pend", 32'(pend_rr), 0);
        tick(1'b0, 8'h41, 1'b1, 1'b0);
        chk("lit_after_rst_y", 32'(y_rr), 0);

        // deterministic mixed traffic, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            logic [7:0] v;
            v = 8'((i * 37) ^ (i << 3));
            tick(1'b0, (i % 3 == 0) ? v : 8'h00, (i % 7) != 3, (i % 4) != 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
